// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for both halves of the 8-entry asynchronous CDC FIFO.
//
// Contents:
//   DEFAULT_ADDR_WIDTH : log2 of the FIFO depth (pointers carry one extra
//                        wrap bit on top of this)
//   DEFAULT_DATA_WIDTH : payload width
//   ptr_t              : pointer type, DEFAULT_ADDR_WIDTH+1 bits
//   bin2gray/gray2bin  : pointer code conversions
//
// The conversion functions work on a 32-bit container so that modules with a
// non-default pointer width can use them. Callers zero-extend their pointer
// into the container and size-cast the result back. Both conversions are
// exact under zero extension because the zero upper bits contribute nothing
// to the XOR chains.
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 3;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

   // Each Gray bit is the XOR of its binary bit and the next higher one.
   function automatic logic [31:0] bin2gray(input logic [31:0] binVal);
      return binVal ^ (binVal >> 1);
   endfunction

   // Each binary bit is the XOR of its Gray bit with every higher Gray bit,
   // so the chain runs from the MSB downwards.
   function automatic logic [31:0] gray2bin(input logic [31:0] grayVal);
      logic [31:0] binVal;
      binVal[31] = grayVal[31];
      for (int i = 30; i >= 0; i--) begin
         binVal[i] = binVal[i+1] ^ grayVal[i];
      end
      return binVal;
   endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl_if
// Signal bundle between the FIFO read controller and its surroundings: the
// write domain, the storage array and the downstream consumer.
//
// Signals:
//   write_ptr_gray    : Gray write pointer arriving from the write domain
//   read_ptr_gray     : registered Gray read pointer sent to the write domain
//   read_addr         : storage read address (binary read pointer)
//   read_enable_1     : storage read strobe
//   mem_read_data     : registered read data coming back from the storage
//   read_data         : payload presented to the consumer
//   read_valid        : payload valid
//   read_ready        : consumer accepts the payload
//   empty             : no unread entries visible in the read domain
//   read_level        : (FIFO_RD_LEVEL_EN) registered fill level
//   read_almost_empty : (FIFO_RD_LEVEL_EN) level at or below threshold
//
// Modports:
//   master : the read controller
//   slave  : everything else (write domain, storage, consumer)
//
// Build option: FIFO_RD_LEVEL_EN adds read_level and read_almost_empty.
// ---------------------------------------------------------------------------
interface fifo_read_ctrl_if
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic [ADDR_WIDTH:0]   write_ptr_gray;
   logic [ADDR_WIDTH:0]   read_ptr_gray;
   logic [ADDR_WIDTH:0]   read_addr;
   logic                  read_enable_1;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_valid;
   logic                  read_ready;
   logic                  empty;
`ifdef FIFO_RD_LEVEL_EN
   logic [ADDR_WIDTH:0]   read_level;
   logic                  read_almost_empty;
`endif

   // The controller's view: it consumes the write pointer, storage data and
   // consumer ready, and drives everything else.
   modport master (
      input  write_ptr_gray,
      input  mem_read_data,
      input  read_ready,
      output read_ptr_gray,
      output read_addr,
      output read_enable_1,
      output read_data,
      output read_valid,
      output empty
`ifdef FIFO_RD_LEVEL_EN
      ,
      output read_level,
      output read_almost_empty
`endif
   );

   // The mirror image, used by whatever sits around the controller.
   modport slave (
      output write_ptr_gray,
      output mem_read_data,
      output read_ready,
      input  read_ptr_gray,
      input  read_addr,
      input  read_enable_1,
      input  read_data,
      input  read_valid,
      input  empty
`ifdef FIFO_RD_LEVEL_EN
      ,
      input  read_level,
      input  read_almost_empty
`endif
   );

endinterface

// File: rtl/fifo_ptr_sync.sv
// ---------------------------------------------------------------------------
// fifo_ptr_sync
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local
// clock domain. Shared by the read controller (for the write pointer) and the
// write controller (for the read pointer).
//
// Because the source is Gray coded, at most one bit changes per source step,
// so sampling the whole vector through plain flops gives either the old or
// the new pointer, never a mix.
//
// Parameters:
//   WIDTH       : vector width
//   SYNC_STAGES : number of flops in the chain; values below 2 are raised to
//                 2 because a single flop gives no metastability margin
//
// Ports:
//   i_clk   : destination-domain clock
//   i_rstN  : synchronous active-low reset, clears every stage
//   i_async : vector from the other clock domain
//   o_sync  : synchronized vector (output of the last stage)
// ---------------------------------------------------------------------------
module fifo_ptr_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [WIDTH-1:0] r_stage [DEPTH];

   // Shift the incoming vector down the chain each clock. Stage 0 is the only
   // flop that sees the asynchronous input; nothing else touches it.
   always_ff @(posedge i_clk) begin
      if (!i_rstN) begin
         for (int s = 0; s < DEPTH; s++) begin
            r_stage[s] <= '0;
         end
      end else begin
         r_stage[0] <= i_async;
         for (int s = 1; s < DEPTH; s++) begin
            r_stage[s] <= r_stage[s-1];
         end
      end
   end

   assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
// Read-side controller of the 8-entry asynchronous CDC FIFO. Everything here
// runs on read_clk.
//
// The controller brings the Gray write pointer into the read domain, compares
// it with its own Gray read pointer to decide emptiness, fetches words from
// the storage array (whose data comes back one clock later) and presents them
// to the consumer as a valid/ready stream. Its Gray read pointer is exported
// to the write domain for the full computation there.
//
// Parameters:
//   ADDR_WIDTH          : log2 of the FIFO depth; pointers are one bit wider
//   DATA_WIDTH          : payload width
//   SYNC_STAGES         : flops in the write-pointer synchronizer (min 2)
//   ALMOST_EMPTY_THRESH : (FIFO_RD_LEVEL_EN) level at/below which
//                         read_almost_empty asserts
//
// Ports:
//   read_clk : read-domain clock
//   read_rst : synchronous active-low reset, sampled on posedge read_clk
//   bus      : fifo_read_ctrl_if.master carrying write_ptr_gray,
//              read_ptr_gray, read_addr, read_enable_1, mem_read_data,
//              read_data, read_valid, read_ready, empty and, with
//              FIFO_RD_LEVEL_EN, read_level and read_almost_empty
//
// Build option: define FIFO_RD_LEVEL_EN to add the fill level and
// almost-empty outputs. The default build leaves both out together with the
// Gray-to-binary conversion they need; the core read path is identical.
// ---------------------------------------------------------------------------
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH          = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES         = 2
`ifdef FIFO_RD_LEVEL_EN
   ,
   parameter int ALMOST_EMPTY_THRESH = 2
`endif
) (
   input  logic             read_clk,
   input  logic             read_rst,
   fifo_read_ctrl_if.master bus
);

   localparam int                  PW      = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   r_rptrBin;
   logic [ADDR_WIDTH:0]   r_rptrGray;
   logic                  r_readValid;
   logic [ADDR_WIDTH:0]   w_wptrSync;
   logic [ADDR_WIDTH:0]   w_rptrBinNext;
   logic [ADDR_WIDTH:0]   w_rptrGrayNext;
   logic                  w_empty;
   logic                  w_issue;
   logic [DATA_WIDTH-1:0] w_readData;

   // The write pointer enters the read domain only through this chain, so
   // an update from the writer becomes visible SYNC_STAGES edges later.
   fifo_ptr_sync #(
      .WIDTH       (PW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_wptrSync (
      .i_clk   (read_clk),
      .i_rstN  (read_rst),
      .i_async (bus.write_ptr_gray),
      .o_sync  (w_wptrSync)
   );

   // Comparing the two Gray pointers directly avoids converting the
   // synchronized write pointer in the default build. A full FIFO differs in
   // the top two Gray bits, so it correctly reads as non-empty.
   assign w_empty = (r_rptrGray == w_wptrSync);

   // A fetch is started whenever a word is available and the output slot is
   // either free or being drained this cycle. Because storage data arrives
   // one clock after the strobe, this keeps exactly one word in flight and
   // gives one word per clock under continuous read_ready.
   assign w_issue = !w_empty && (!r_readValid || bus.read_ready);

   assign w_rptrBinNext  = r_rptrBin + PTR_ONE;
   assign w_rptrGrayNext = PW'(bin2gray(32'(w_rptrBinNext)));

   // Read pointer and output-valid flag. Both pointer codes advance together
   // on each fetch; the binary form wraps naturally at 2^(ADDR_WIDTH+1) and
   // the Gray form follows it. read_valid rises on the edge that lands the
   // fetched word and falls once the consumer takes the last word without a
   // replacement being fetched. A reset drops any word still in flight.
   always_ff @(posedge read_clk) begin
      if (!read_rst) begin
         r_rptrBin   <= '0;
         r_rptrGray  <= '0;
         r_readValid <= 1'b0;
      end else begin
         if (w_issue) begin
            r_rptrBin  <= w_rptrBinNext;
            r_rptrGray <= w_rptrGrayNext;
         end
         if (w_issue) begin
            r_readValid <= 1'b1;
         end else if (bus.read_ready) begin
            r_readValid <= 1'b0;
         end
      end
   end

   // The storage holds its registered output while no strobe is given, so
   // the payload stays stable through backpressure without a local copy.
   assign w_readData = bus.mem_read_data;

   assign bus.read_ptr_gray = r_rptrGray;
   assign bus.read_addr     = r_rptrBin;
   assign bus.read_enable_1 = w_issue;
   assign bus.read_data     = w_readData;
   assign bus.read_valid    = r_readValid;
   assign bus.empty         = w_empty;

`ifdef FIFO_RD_LEVEL_EN
   localparam logic [ADDR_WIDTH:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

   logic [ADDR_WIDTH:0] w_wptrBin;
   logic [ADDR_WIDTH:0] r_readLevel;

   assign w_wptrBin = PW'(gray2bin(32'(w_wptrSync)));

   // Fill level seen from the read side, registered to keep the subtractor
   // off the output path. The modular difference is exact because the two
   // pointers never drift more than the FIFO depth apart.
   always_ff @(posedge read_clk) begin
      if (!read_rst) begin
         r_readLevel <= '0;
      end else begin
         r_readLevel <= w_wptrBin - r_rptrBin;
      end
   end

   assign bus.read_level        = r_readLevel;
   assign bus.read_almost_empty = (r_readLevel <= AE_THRESH);
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_ctrl
// Self-checking bench for fifo_read_ctrl. A behavioural storage array with a
// registered read port sits beside the controller; words written into it are
// queued as expected payload and address, and a monitor pops the queues on
// every storage strobe and every consumer handshake. Directed sequences cover
// reset, first-word latency, a full FIFO, backpressure, pointer wrap and a
// mid-stream reset. Build with FIFO_RD_LEVEL_EN to also check the level port.
// ---------------------------------------------------------------------------
module tb_fifo_read_ctrl;

   logic read_clk;
   logic read_rst;

   int nChecks;
   int nFails;

   logic [7:0]     mem [8];
   logic [7:0]     expData[$];
   logic [3:0]     expAddr[$];
   fifo_pkg::ptr_t wbin;

   fifo_read_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

   fifo_read_ctrl #(
      .ADDR_WIDTH  (3),
      .DATA_WIDTH  (8),
      .SYNC_STAGES (2)
   ) dut (
      .read_clk (read_clk),
      .read_rst (read_rst),
      .bus      (bus.master)
   );

   // 10 ns read clock.
   initial begin
      read_clk = 1'b0;
      forever #5 read_clk = ~read_clk;
   end

   // Storage model: registered read port that holds its output when not
   // strobed, matching the array the controller is meant to drive.
   always @(posedge read_clk) begin
      if (!read_rst) begin
         bus.mem_read_data <= 8'h00;
      end else if (bus.read_enable_1) begin
         bus.mem_read_data <= mem[bus.read_addr[2:0]];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every strobe must hit the next expected address and every
   // handshake must carry the next expected word.
   always @(negedge read_clk) begin
      if (read_rst === 1'b1) begin
         if (bus.read_enable_1 === 1'b1) begin
            if (expAddr.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected_strobe: got addr 0x%0h, expected no strobe", bus.read_addr);
            end else begin
               checkOutput("read_addr_seq", 32'(bus.read_addr), 32'(expAddr.pop_front()));
            end
         end
         if (bus.read_valid === 1'b1 && bus.read_ready === 1'b1) begin
            if (expData.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", bus.read_data);
            end else begin
               checkOutput("read_data_seq", 32'(bus.read_data), 32'(expData.pop_front()));
            end
         end
      end
   end

   // Move to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge read_clk);
      #1;
   endtask

   // Write one word into the storage model and publish the new write pointer.
   task automatic applyStimulus(input logic [7:0] data);
      mem[wbin[2:0]] = data;
      expData.push_back(data);
      expAddr.push_back(wbin);
      wbin = wbin + 4'd1;
      bus.write_ptr_gray = wbin ^ (wbin >> 1);
   endtask

   // Reset both sides together and forget anything queued.
   task automatic applyReset();
      read_rst = 1'b0;
      bus.read_ready = 1'b0;
      wbin = '0;
      bus.write_ptr_gray = '0;
      expData.delete();
      expAddr.delete();
      repeat (3) tick();
      read_rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int issues, beats, firstIssue, lastIssue, firstBeat, lastBeat;
      logic [3:0] wrapGray [5];

      nChecks = 0;
      nFails  = 0;
      read_rst = 1'b0;
      bus.read_ready = 1'b0;
      wbin = '0;
      bus.write_ptr_gray = '0;

      // Reset state after three reset edges.
      repeat (3) @(posedge read_clk);
      @(negedge read_clk);
      checkOutput("rst_empty", 32'(bus.empty), 32'd1);
      checkOutput("rst_valid", 32'(bus.read_valid), 32'd0);
      checkOutput("rst_rptr_gray", 32'(bus.read_ptr_gray), 32'd0);
      checkOutput("rst_rd_en", 32'(bus.read_enable_1), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
      checkOutput("rst_level", 32'(bus.read_level), 32'd0);
      checkOutput("rst_almost_empty", 32'(bus.read_almost_empty), 32'd1);
`endif
      tick();
      read_rst = 1'b1;
      bus.read_ready = 1'b1;

      // Single word: two synchronizer edges, then one edge to valid.
      tick();
      applyStimulus(8'hA5);
      @(negedge read_clk);
      checkOutput("w1_e0_empty", 32'(bus.empty), 32'd1);
      tick();
      @(negedge read_clk);
      checkOutput("w1_e1_empty", 32'(bus.empty), 32'd1);
      tick();
      @(negedge read_clk);
      checkOutput("w1_e2_empty", 32'(bus.empty), 32'd0);
      checkOutput("w1_e2_rd_en", 32'(bus.read_enable_1), 32'd1);
      checkOutput("w1_e2_addr", 32'(bus.read_addr), 32'd0);
      tick();
      @(negedge read_clk);
      checkOutput("w1_e3_valid", 32'(bus.read_valid), 32'd1);
      checkOutput("w1_e3_empty", 32'(bus.empty), 32'd1);
      checkOutput("w1_e3_rptr_gray", 32'(bus.read_ptr_gray), 32'h1);
      checkOutput("w1_e3_rd_en", 32'(bus.read_enable_1), 32'd0);
      tick();
      @(negedge read_clk);
      checkOutput("w1_e4_valid", 32'(bus.read_valid), 32'd0);

      // Full FIFO: eight back-to-back fetches and beats.
      tick();
      applyReset();
      bus.read_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'h10 + 8'(i));
      end
      issues = 0;
      beats = 0;
      firstIssue = -1;
      lastIssue = -1;
      firstBeat = -1;
      lastBeat = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge read_clk);
         if (c == 2) begin
            checkOutput("full_not_empty", 32'(bus.empty), 32'd0);
         end
         if (bus.read_enable_1 === 1'b1) begin
            issues++;
            if (firstIssue < 0) firstIssue = c;
            lastIssue = c;
         end
         if (bus.read_valid === 1'b1) begin
            beats++;
            if (firstBeat < 0) firstBeat = c;
            lastBeat = c;
         end
         tick();
      end
      checkOutput("full_issue_count", 32'(issues), 32'd8);
      checkOutput("full_issue_span", 32'(lastIssue - firstIssue), 32'd7);
      checkOutput("full_beat_count", 32'(beats), 32'd8);
      checkOutput("full_beat_span", 32'(lastBeat - firstBeat), 32'd7);
      @(negedge read_clk);
      checkOutput("full_end_empty", 32'(bus.empty), 32'd1);
      checkOutput("full_end_rptr_gray", 32'(bus.read_ptr_gray), 32'hC);

      // Backpressure: one word held, three queued behind it.
      tick();
      bus.read_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h21 + 8'(i));
      end
      tick();
      tick();
      @(negedge read_clk);
      checkOutput("bp_first_fetch", 32'(bus.read_enable_1), 32'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge read_clk);
         checkOutput("bp_hold_valid", 32'(bus.read_valid), 32'd1);
         checkOutput("bp_hold_rd_en", 32'(bus.read_enable_1), 32'd0);
         checkOutput("bp_hold_data", 32'(bus.read_data), 32'h21);
`ifdef FIFO_RD_LEVEL_EN
         if (k == 3) begin
            checkOutput("bp_level", 32'(bus.read_level), 32'd3);
            checkOutput("bp_almost_empty", 32'(bus.read_almost_empty), 32'd0);
         end
`endif
         tick();
      end
      bus.read_ready = 1'b1;
      @(negedge read_clk);
      checkOutput("bp_pop_and_issue_valid", 32'(bus.read_valid), 32'd1);
      checkOutput("bp_pop_and_issue_rd_en", 32'(bus.read_enable_1), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge read_clk);
         checkOutput("bp_release_valid", 32'(bus.read_valid), 32'd1);
      end
      tick();
      @(negedge read_clk);
      checkOutput("bp_end_valid", 32'(bus.read_valid), 32'd0);
      checkOutput("bp_end_empty", 32'(bus.empty), 32'd1);
      checkOutput("bp_end_rptr_gray", 32'(bus.read_ptr_gray), 32'hA);

      // Wrap: bring the read pointer to 14, then read 14, 15, 0, 1.
      tick();
      applyStimulus(8'h31);
      applyStimulus(8'h32);
      repeat (5) tick();
      @(negedge read_clk);
      checkOutput("wrap_pre_rptr_gray", 32'(bus.read_ptr_gray), 32'h9);
      checkOutput("wrap_pre_empty", 32'(bus.empty), 32'd1);
      wrapGray[0] = 4'b1001;
      wrapGray[1] = 4'b1000;
      wrapGray[2] = 4'b0000;
      wrapGray[3] = 4'b0001;
      wrapGray[4] = 4'b0011;
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h41 + 8'(i));
      end
      tick();
      tick();
      @(negedge read_clk);
      checkOutput("wrap_gray_0", 32'(bus.read_ptr_gray), 32'(wrapGray[0]));
      checkOutput("wrap_addr_0", 32'(bus.read_addr), 32'd14);
      checkOutput("wrap_rd_en_0", 32'(bus.read_enable_1), 32'd1);
      for (int k = 1; k < 5; k++) begin
         tick();
         @(negedge read_clk);
         checkOutput("wrap_gray", 32'(bus.read_ptr_gray), 32'(wrapGray[k]));
         checkOutput("wrap_rd_en", 32'(bus.read_enable_1), (k < 4) ? 32'd1 : 32'd0);
      end
      checkOutput("wrap_end_empty", 32'(bus.empty), 32'd1);
      tick();
      tick();
      @(negedge read_clk);
      checkOutput("wrap_data_queue_drained", 32'(expData.size()), 32'd0);
      checkOutput("wrap_addr_queue_drained", 32'(expAddr.size()), 32'd0);

      // Mid-stream reset with one word valid and three pending.
      tick();
      bus.read_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h51 + 8'(i));
      end
      tick();
      tick();
      tick();
      @(negedge read_clk);
      checkOutput("mrst_pre_valid", 32'(bus.read_valid), 32'd1);
      tick();
      read_rst = 1'b0;
      wbin = '0;
      bus.write_ptr_gray = '0;
      expData.delete();
      expAddr.delete();
      tick();
      @(negedge read_clk);
      checkOutput("mrst_valid", 32'(bus.read_valid), 32'd0);
      checkOutput("mrst_rptr_gray", 32'(bus.read_ptr_gray), 32'd0);
      checkOutput("mrst_addr", 32'(bus.read_addr), 32'd0);
      checkOutput("mrst_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
      checkOutput("mrst_level", 32'(bus.read_level), 32'd0);
      checkOutput("mrst_almost_empty", 32'(bus.read_almost_empty), 32'd1);
`endif
      tick();
      read_rst = 1'b1;
      bus.read_ready = 1'b1;
      repeat (3) tick();
      @(negedge read_clk);
      checkOutput("mrst_after_valid", 32'(bus.read_valid), 32'd0);
      checkOutput("mrst_after_empty", 32'(bus.empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
